// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Execute-side partner of the fetch branch predictor. It checks each resolved
// control-flow instruction against the prediction fetch made for it. On a
// misprediction it sends fetch a registered one-cycle redirect. Branch
// outcomes are queued in a small FIFO and drained one per cycle onto the
// predictor update port. Two saturating performance counters are kept.
//
// Ports
//   clk, resetn           : clock, async active-low reset
//   res_*                 : resolved instruction + carried prediction (valid/ready)
//   redirect_valid/_pc    : one-cycle fetch redirect to the corrected next PC
//   upd_*                 : predictor training update, upd_en strobe
//   br_cnt, mispred_cnt   : accepted branches / redirects issued (saturating)
module branch_resolve_unit #(
  parameter int unsigned UPD_FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [31:0]          res_pc,
  input  logic                 res_is_br,
  input  logic                 res_is_cond,
  input  logic                 res_taken,
  input  logic [31:0]          res_target,
  input  logic                 res_pred_taken,
  input  logic [31:0]          res_pred_target,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 upd_en,
  output logic [31:0]          upd_inst_addr,
  output logic                 upd_br_inst,
  output logic                 upd_cond_br_inst,
  output logic                 upd_br_taken,
  output logic [31:0]          upd_br_target,
  output logic [CNT_WIDTH-1:0] br_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam int unsigned PTR_W = (UPD_FIFO_DEPTH > 1) ? $clog2(UPD_FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        is_cond;
    logic        taken;
    logic [31:0] target;
  } upd_entry_t;

  // State
  upd_entry_t           r_mem [UPD_FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [OCC_W-1:0]     r_count;
  logic                 r_run;
  logic                 r_redirect_valid;
  logic [31:0]          r_redirect_pc;
  logic [CNT_WIDTH-1:0] r_br_cnt;
  logic [CNT_WIDTH-1:0] r_mispred_cnt;

  // Combinational
  logic                 w_full;
  logic                 w_nonempty;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_taken;
  logic [31:0]          w_pc_plus4;
  logic [31:0]          w_actual_npc;
  logic                 w_mispred;
  upd_entry_t           w_new;
  upd_entry_t           w_head;

  assign w_full     = (r_count == OCC_W'(UPD_FIFO_DEPTH));
  assign w_nonempty = (r_count != '0);

  // Ready is held low until the first edge after reset; a pop never frees a slot the same cycle
  assign res_ready  = r_run & ~w_full;
  assign w_accept   = res_valid & res_ready;
  assign w_push     = w_accept & res_is_br;
  assign w_pop      = w_nonempty;

  // Unconditional branches are always taken; non-branches fall through
  assign w_taken      = res_is_br & (res_taken | ~res_is_cond);
  assign w_pc_plus4   = res_pc + 32'd4;
  assign w_actual_npc = w_taken ? res_target : w_pc_plus4;

  // Mispredict: wrong direction, wrong taken target, or a BTB alias hit on a non-branch
  always_comb begin
    w_mispred = 1'b0;
    if (res_is_br) begin
      w_mispred = (res_pred_taken != w_taken) ||
                  (w_taken && res_pred_taken && (res_pred_target != res_target));
    end else begin
      w_mispred = res_pred_taken;
    end
  end

  always_comb begin
    w_new         = '0;
    w_new.pc      = res_pc;
    w_new.is_cond = res_is_cond;
    w_new.taken   = w_taken;
    w_new.target  = res_target;
  end

  assign w_head = r_mem[r_rd_ptr];

  // Update FIFO storage (contents need no reset; validity comes from r_count)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Run flag, redirect and counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run            <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_br_cnt         <= '0;
      r_mispred_cnt    <= '0;
    end else begin
      r_run            <= 1'b1;
      r_redirect_valid <= w_accept & w_mispred;
      if (w_accept && w_mispred) begin
        r_redirect_pc <= w_actual_npc;
      end
      if (w_push && (r_br_cnt != {CNT_WIDTH{1'b1}})) begin
        r_br_cnt <= r_br_cnt + CNT_WIDTH'(1);
      end
      if (w_accept && w_mispred && (r_mispred_cnt != {CNT_WIDTH{1'b1}})) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign redirect_valid   = r_redirect_valid;
  assign redirect_pc      = r_redirect_pc;
  assign br_cnt           = r_br_cnt;
  assign mispred_cnt      = r_mispred_cnt;

  // Head of FIFO drives the update port; fields read as zero when idle
  assign upd_en           = w_nonempty;
  assign upd_br_inst      = w_nonempty;
  assign upd_inst_addr    = w_nonempty ? w_head.pc     : 32'd0;
  assign upd_cond_br_inst = w_nonempty & w_head.is_cond;
  assign upd_br_taken     = w_nonempty & w_head.taken;
  assign upd_br_target    = w_nonempty ? w_head.target : 32'd0;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: scoreboard of expected updates,
// reference model for redirects / counters / ready, directed + random stimulus.
module tb_branch_resolve_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic        cond;
    logic        tk;
    logic [31:0] tgt;
  } exp_upd_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [31:0]   res_pc = '0;
  logic          res_is_br = 1'b0;
  logic          res_is_cond = 1'b0;
  logic          res_taken = 1'b0;
  logic [31:0]   res_target = '0;
  logic          res_pred_taken = 1'b0;
  logic [31:0]   res_pred_target = '0;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          upd_en;
  logic [31:0]   upd_inst_addr;
  logic          upd_br_inst;
  logic          upd_cond_br_inst;
  logic          upd_br_taken;
  logic [31:0]   upd_br_target;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] mispred_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int n_upd = 0;

  // Reference model state
  exp_upd_t      q_upd[$];
  int            m_occ;
  logic          m_ready;
  logic          m_redir_valid;
  logic [31:0]   m_redir_pc;
  logic [CW-1:0] m_br;
  logic [CW-1:0] m_mis;

  branch_resolve_unit #(.UPD_FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
    .res_is_br(res_is_br), .res_is_cond(res_is_cond), .res_taken(res_taken),
    .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_inst_addr(upd_inst_addr), .upd_br_inst(upd_br_inst),
    .upd_cond_br_inst(upd_cond_br_inst), .upd_br_taken(upd_br_taken),
    .upd_br_target(upd_br_target), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_upd.delete();
    m_occ         = 0;
    m_ready       = 1'b0;
    m_redir_valid = 1'b0;
    m_redir_pc    = '0;
    m_br          = '0;
    m_mis         = '0;
  endtask

  // Expected behaviour derived from the resolve rules, evaluated at each rising edge
  task automatic model_step();
    logic        acc;
    logic        pop;
    logic        tk;
    logic        mis;
    logic [31:0] npc;
    exp_upd_t    e;
    acc = res_valid && m_ready;
    pop = (m_occ > 0);
    m_redir_valid = 1'b0;
    if (acc) begin
      tk  = res_is_br && (res_taken || !res_is_cond);
      npc = tk ? res_target : (res_pc + 32'd4);
      if (!res_is_br)                              mis = res_pred_taken;
      else if (res_pred_taken != tk)               mis = 1'b1;
      else if (tk && (res_pred_target != res_target)) mis = 1'b1;
      else                                         mis = 1'b0;
      if (mis) begin
        m_redir_valid = 1'b1;
        m_redir_pc    = npc;
        if (m_mis != '1) m_mis = m_mis + 1;
      end
      if (res_is_br) begin
        e.pc = res_pc; e.cond = res_is_cond; e.tk = tk; e.tgt = res_target;
        q_upd.push_back(e);
        m_occ++;
        if (m_br != '1) m_br = m_br + 1;
      end
    end
    if (pop) m_occ--;
    m_ready = (m_occ < int'(DEPTH));
  endtask

  task automatic model_loop();
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else         model_step();
    end
  endtask

  // Compare every DUT output against the model on the falling edge
  task automatic monitor_loop();
    exp_upd_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk("ready", 64'(res_ready), 64'(m_ready));
        chk("redir_valid", 64'(redirect_valid), 64'(m_redir_valid));
        chk("redir_pc", 64'(redirect_pc), 64'(m_redir_pc));
        chk("br_cnt", 64'(br_cnt), 64'(m_br));
        chk("mispred_cnt", 64'(mispred_cnt), 64'(m_mis));
        chk("upd_en", 64'(upd_en), 64'(q_upd.size() != 0));
        if (upd_en && q_upd.size() != 0) begin
          e = q_upd.pop_front();
          n_upd++;
          chk("upd_addr", 64'(upd_inst_addr), 64'(e.pc));
          chk("upd_flags", 64'({upd_br_inst, upd_cond_br_inst, upd_br_taken}),
              64'({1'b1, e.cond, e.tk}));
          chk("upd_target", 64'(upd_br_target), 64'(e.tgt));
        end else if (!upd_en) begin
          chk("upd_idle", 64'({upd_inst_addr, upd_br_target}), 64'(0));
          chk("upd_idle_flags", 64'({upd_br_inst, upd_cond_br_inst, upd_br_taken}), 64'(0));
        end
      end
    end
  endtask

  // One cycle of a valid transfer; returns on the falling edge after the accept edge
  task automatic drive(input logic [31:0] pc, input logic is_br, input logic is_cond,
                       input logic taken, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    res_valid = 1'b1; res_pc = pc; res_is_br = is_br; res_is_cond = is_cond;
    res_taken = taken; res_target = tgt; res_pred_taken = pt; res_pred_target = ptgt;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({res_ready, redirect_valid, upd_en, upd_br_inst,
                            upd_cond_br_inst, upd_br_taken}), 64'(0));
    chk({tag, "_redir_pc"}, 64'(redirect_pc), 64'(0));
    chk({tag, "_upd_addr"}, 64'({upd_inst_addr, upd_br_target}), 64'(0));
    chk({tag, "_cnts"}, 64'({br_cnt, mispred_cnt}), 64'(0));
  endtask

  initial begin
    int          base_upd;
    logic [31:0] pc, tgt, ptgt;
    logic        br, cond, tk, pt;

    fork
      model_loop();
      monitor_loop();
    join_none

    // Power-on reset
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("por");
    resetn = 1'b1;
    idle(2);
    chk("post_rst_ready", 64'(res_ready), 64'(1));
    chk("post_rst_upd_en", 64'(upd_en), 64'(0));

    // Correct conditional not-taken
    drive(32'h1C00_0100, 1, 1, 0, 32'h1C00_0180, 0, 32'h1C00_0104);
    chk("cnt_redir", 64'(redirect_valid), 64'(0));
    chk("cnt_upd_en", 64'(upd_en), 64'(1));
    chk("cnt_upd_addr", 64'(upd_inst_addr), 64'(32'h1C00_0100));
    chk("cnt_upd_tk_cond", 64'({upd_br_taken, upd_cond_br_inst}), 64'(2'b01));
    chk("cnt_counts", 64'({br_cnt, mispred_cnt}), {32'd1, 32'd0});

    // Direction mispredict
    drive(32'h1C00_0200, 1, 1, 1, 32'h1C00_0080, 0, 32'h1C00_0204);
    chk("dir_redir", 64'(redirect_valid), 64'(1));
    chk("dir_redir_pc", 64'(redirect_pc), 64'(32'h1C00_0080));
    chk("dir_upd", 64'({upd_br_taken, upd_br_target}), 64'({1'b1, 32'h1C00_0080}));
    chk("dir_mis", 64'(mispred_cnt), 64'(1));

    // Jump target mispredict
    drive(32'h1C00_0300, 1, 0, 1, 32'h1C00_0500, 1, 32'h1C00_0400);
    chk("tgt_redir", 64'({redirect_valid, redirect_pc}), 64'({1'b1, 32'h1C00_0500}));
    chk("tgt_mis", 64'(mispred_cnt), 64'(2));

    // BTB alias on a non-branch at the top of the address space
    drive(32'hFFFF_FFFC, 0, 0, 0, 32'h0, 1, 32'h1234_5678);
    chk("alias_redir", 64'({redirect_valid, redirect_pc}), 64'({1'b1, 32'h0}));
    chk("alias_upd_en", 64'(upd_en), 64'(0));
    chk("alias_cnts", 64'({br_cnt, mispred_cnt}), {32'd3, 32'd3});
    idle(2);

    // Back-to-back stream of six branches
    base_upd = n_upd;
    for (int i = 0; i < 6; i++) begin
      pc  = 32'h1C00_1000 + 32'(i * 16);
      tk  = 1'(i & 1);
      tgt = pc + 32'h40;
      drive(pc, 1, 1, tk, tgt, tk, tk ? tgt : pc + 32'd4);
      chk("stream_rdy", 64'(res_ready), 64'(1));
    end
    idle(3);
    chk("stream_upd_count", 64'(n_upd - base_upd), 64'(6));

    // Randomised traffic
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
        br   = ($urandom_range(0, 3) != 0);
        cond = 1'($urandom_range(0, 1));
        tk   = cond ? 1'($urandom_range(0, 1)) : 1'b1;
        tgt  = $urandom() & 32'hFFFF_FFFC;
        pt   = 1'($urandom_range(0, 1));
        ptgt = ($urandom_range(0, 1) == 1) ? tgt : ($urandom() & 32'hFFFF_FFFC);
        drive(pc, br, cond, tk, tgt, pt, ptgt);
      end else begin
        idle(1);
      end
    end
    idle(2);

    // Reset in the middle of a stream
    drive(32'h2000_0000, 1, 1, 1, 32'h2000_0100, 0, 32'h0);
    drive(32'h2000_0004, 1, 0, 1, 32'h2000_0200, 1, 32'h2000_0200);
    drive(32'h2000_0008, 1, 1, 0, 32'h2000_0300, 0, 32'h0);
    #2 resetn = 1'b0;
    #1 chk_reset_outputs("mid");
    idle(2);
    #2 resetn = 1'b1;
    @(negedge clk);
    chk("mid_post_ready", 64'(res_ready), 64'(1));
    chk("mid_post_upd_en", 64'(upd_en), 64'(0));
    chk("mid_post_br_cnt", 64'(br_cnt), 64'(0));

    // Counter saturation
    #1;
    force dut.r_br_cnt = 32'hFFFF_FFFF;
    force dut.r_mispred_cnt = 32'hFFFF_FFFF;
    m_br  = '1;
    m_mis = '1;
    #1;
    release dut.r_br_cnt;
    release dut.r_mispred_cnt;
    @(negedge clk);
    chk("sat_pre", 64'({br_cnt, mispred_cnt}), 64'hFFFF_FFFF_FFFF_FFFF);
    drive(32'h1C00_0600, 1, 1, 1, 32'h1C00_0700, 0, 32'h0);
    chk("sat_redir", 64'({redirect_valid, redirect_pc}), 64'({1'b1, 32'h1C00_0700}));
    chk("sat_post", 64'({br_cnt, mispred_cnt}), 64'hFFFF_FFFF_FFFF_FFFF);

    idle(4);
    chk("drain_empty", 64'(q_upd.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
